// File: rtl/ebc_event_packer.sv
// ebc_event_packer: receiving end of the EBC row/column arbitration path.
// Takes one granted pixel event per cycle, packs it into a fixed-width word
// and buffers it in a first-word-fall-through FIFO with a valid/ready output.
// Optional feature macro: EBC_TS_EN. When it is defined, each event carries a
// free-running timestamp and a marker packet is queued whenever the timestamp
// wraps. When it is undefined, packets are {type=0, y, x, pol}.
module ebc_event_packer #(
  parameter  int ADDR_W = 2,
  parameter  int TS_W   = 16,
  parameter  int DEPTH  = 8,
  localparam int LVL_W  = $clog2(DEPTH) + 1,
`ifdef EBC_TS_EN
  localparam int PKT_W  = 1 + TS_W + 2*ADDR_W + 1
`else
  localparam int PKT_W  = 2*ADDR_W + 2
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              evt_valid_i,
  input  logic [ADDR_W-1:0] x_add_i,
  input  logic [ADDR_W-1:0] y_add_i,
  input  logic              pol_i,
  output logic              evt_ready_o,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [PKT_W-1:0]  pkt_data_o,
  output logic [LVL_W-1:0]  fifo_level_o
);

  localparam int AW = LVL_W - 1;

  // Parameter sanity: DEPTH must be a power of two and at least 2.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_W < 1 || ADDR_W < 1) begin : g_bad_params
    $error("ebc_event_packer: illegal parameters");
  end

  logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             evt_ready_q, evt_ready_d;
  logic             full, empty;
  logic             evt_acc, mark_wr, push, pop;
  logic [PKT_W-1:0] wr_data;
  logic [PKT_W-1:0] mem [DEPTH];

`ifdef EBC_TS_EN
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             ts_wrap;
  logic             ovf_pend_q, ovf_pend_d;
`endif

  // Next-state logic: accept/marker write, pop, pointers, level and ready.
  always_comb begin
    full    = (level_q == LVL_W'(DEPTH));
    empty   = (level_q == '0);
    // evt_ready_q already excludes full and pending-marker cycles, so an
    // event is never written in the same edge as a marker.
    evt_acc = evt_valid_i && evt_ready_q;
    pop     = !empty && pkt_ready_i;
`ifdef EBC_TS_EN
    ts_d       = ts_q + 1'b1;
    ts_wrap    = (ts_q == '1);
    mark_wr    = ovf_pend_q && !full;
    // A wrap while a marker is still pending just keeps the flag set, so at
    // most one marker is ever outstanding.
    ovf_pend_d = ts_wrap || (ovf_pend_q && !mark_wr);
    if (mark_wr)
      wr_data = {1'b1, {(PKT_W-1){1'b0}}};
    else
      wr_data = {1'b0, ts_q, y_add_i, x_add_i, pol_i};
`else
    mark_wr = 1'b0;
    wr_data = {1'b0, y_add_i, x_add_i, pol_i};
`endif
    push     = mark_wr || evt_acc;
    wr_ptr_d = wr_ptr_q + LVL_W'(push);
    rd_ptr_d = rd_ptr_q + LVL_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
    // Ready is registered from the next state so it is low during reset and
    // rises on the first edge after release; no bypass when full.
`ifdef EBC_TS_EN
    evt_ready_d = (level_d != LVL_W'(DEPTH)) && !ovf_pend_d;
`else
    evt_ready_d = (level_d != LVL_W'(DEPTH));
`endif
  end

  // Control state: pointers, occupancy, ready and (optionally) timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      evt_ready_q <= 1'b0;
`ifdef EBC_TS_EN
      ts_q        <= '0;
      ovf_pend_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      evt_ready_q <= evt_ready_d;
`ifdef EBC_TS_EN
      ts_q        <= ts_d;
      ovf_pend_q  <= ovf_pend_d;
`endif
    end
  end

  // Packet storage; contents need no reset because the output is gated by empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // First-word-fall-through output: head entry, forced to zero when empty.
  always_comb begin
    evt_ready_o  = evt_ready_q;
    pkt_valid_o  = !empty;
    fifo_level_o = level_q;
    pkt_data_o   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

endmodule
